spi_frame_receiver: RTL
=======================

Name: spi_frame_receiver

Overview:
- Upstream neighbour of the HUB75 display controller, synchronous to the controller's system clock.
- Oversamples the host SPI bus (mode 0, MSB first) and assembles BITS_PER_PIXEL-bit pixel words.
- Issues one write strobe per word, with address and data, into the double-buffered frame RAM.
- Owns the double-buffer flip: buffers swap only after a complete, well-formed frame.

Parameters:
- BITS_PER_PIXEL, 16, width of one pixel word (RGB fields plus unused low field).
- ADDR_BITS, 10, width of the per-buffer pixel address.
- PIXELS_PER_FRAME, 1024, words required for a valid frame (64 columns x 16 rows).

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- n_reset  in  1  active-low reset.
- spi_clk  in  1  host SPI clock, asynchronous to clk.
- spi_mosi  in  1  host SPI data, asynchronous.
- spi_ss  in  1  host slave select, active low, asynchronous.
- spi_miso  out  1  status to host: 1 = last frame accepted.
- wr_en  out  1  one-cycle write strobe to the frame RAM.
- wr_addr  out  ADDR_BITS  pixel address within the back buffer.
- wr_data  out  BITS_PER_PIXEL  assembled pixel word.
- wr_buffer  out  1  buffer select for writes (back buffer).
- display_buffer  out  1  buffer select for the display read side; always ~wr_buffer.
- frame_done  out  1  one-cycle pulse on a successful buffer swap.
- frame_error  out  1  one-cycle pulse on a rejected frame.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, n_reset).
- Reset values: wr_en=0, wr_addr=0, wr_data=0, wr_buffer=1, display_buffer=0, frame_done=0, frame_error=0, spi_miso=0. Reset also clears the shift register, bit count and pixel count, and forces IDLE. Reset mid-frame discards everything received.
- Synchronisers: spi_clk, spi_mosi and spi_ss each pass through 2 flops, plus a third flop on spi_clk and spi_ss for edge detection.
- Host constraint: spi_clk at most clk/8. Behaviour above that rate is undefined.
- States:
  - IDLE: synced ss high. Go to RECEIVE on synced ss falling; clear bit count and pixel count.
  - RECEIVE: on each synced spi_clk rising edge, shift synced mosi into the LSB and increment bit count.
  - When bit count wraps (BITS_PER_PIXEL bits), go to COMMIT if pixel count < PIXELS_PER_FRAME. Otherwise set an overflow flag and drop the word.
  - COMMIT: one cycle. Drives wr_en=1, wr_data=shift register, wr_addr=pixel count. Pixel count increments; return to RECEIVE.
- Latency: wr_en is asserted 2 clk cycles after the cycle in which the last bit's rising edge is detected.
- wr_addr and wr_data hold their values after wr_en falls.
- On synced ss rising, the state machine goes to IDLE and one of the following applies:
  - Swap condition: pixel count == PIXELS_PER_FRAME, bit count == 0 and no overflow. Then wr_buffer toggles, display_buffer takes the old wr_buffer value, frame_done pulses and spi_miso is set to 1.
  - Zero pixels and bit count 0: no pulse and no status change (idle select pulse).
  - Any other case (short frame, partial word or overflow): frame_error pulses, spi_miso is set to 0 and the buffers do not swap. A partial word is discarded.
- Simultaneous events:
  - An ss rising edge and an spi_clk edge detected in the same cycle: ss wins and the clock edge is ignored.
  - A COMMIT pending when ss rises completes first; ss handling follows in the next cycle.
- Wrap-around: pixel count is ADDR_BITS+1 wide, so overflow is detectable. wr_addr never exceeds PIXELS_PER_FRAME-1.
- spi_ss high forces the shift path idle. spi_clk toggling while ss is high has no effect.

Test Plan:
- Reset, then a 1024-word frame with word n = n: wr_en pulses 1024 times, wr_addr = 0..1023, wr_data = 0x0000..0x03FF, then frame_done=1 for one cycle, wr_buffer 1->0, display_buffer 0->1, spi_miso=1.
- Short frame of 1000 words: 1000 writes, frame_error pulse, buffers unchanged, spi_miso=0.
- Frame of 1024 words plus 5 extra bits before ss rises: last write at addr 1023, partial word discarded, frame_error pulse, no swap.
- Overflow frame of 1030 words: exactly 1024 writes, frame_error, no swap.
- Assert n_reset mid-frame after 300 words, release, then send a full frame: no error pulse during reset, outputs at reset values, next frame swaps normally.
- ss pulsed low/high with no clocks: no wr_en, no frame_done, no frame_error. Two back-to-back good frames: wr_buffer toggles 1->0->1.

Source files
------------

// File: rtl/spi_frame_receiver_if.sv
// Write-side bus from the SPI frame receiver into the double-buffered frame RAM.
// master = receiver (drives), slave = frame RAM / display controller (observes).
interface spi_frame_receiver_if #(
    parameter int BITS_PER_PIXEL = 16,
    parameter int ADDR_BITS      = 10
);
    logic                      wr_en;
    logic [ADDR_BITS-1:0]      wr_addr;
    logic [BITS_PER_PIXEL-1:0] wr_data;
    logic                      wr_buffer;
    logic                      display_buffer;
    logic                      frame_done;
    logic                      frame_error;

    modport master (
        output wr_en, wr_addr, wr_data, wr_buffer, display_buffer, frame_done, frame_error
    );

    modport slave (
        input wr_en, wr_addr, wr_data, wr_buffer, display_buffer, frame_done, frame_error
    );
endinterface

// File: rtl/spi_frame_receiver.sv
// Oversampling SPI (mode 0, MSB first) pixel receiver feeding a double-buffered frame RAM.
// Buffers flip only after exactly PIXELS_PER_FRAME whole words arrive inside one ss window.
module spi_frame_receiver #(
    parameter int BITS_PER_PIXEL   = 16,
    parameter int ADDR_BITS        = 10,
    parameter int PIXELS_PER_FRAME = 1024
) (
    input  logic clk,
    input  logic n_reset,
    input  logic spi_clk,
    input  logic spi_mosi,
    input  logic spi_ss,
    output logic spi_miso,
    spi_frame_receiver_if.master wr_if
);
    localparam int BC_W = (BITS_PER_PIXEL > 1) ? $clog2(BITS_PER_PIXEL) : 1;
    localparam int PC_W = ADDR_BITS + 1;
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(BITS_PER_PIXEL - 1);
    localparam logic [PC_W-1:0] PIX_FULL = PC_W'(PIXELS_PER_FRAME);

    typedef enum logic [1:0] {IDLE, RECEIVE, COMMIT} state_t;

    state_t                    state_q, state_d;
    logic [2:0]                sclk_sync_q, sclk_sync_d;
    logic [1:0]                mosi_sync_q, mosi_sync_d;
    logic [2:0]                ss_sync_q, ss_sync_d;
    logic [BITS_PER_PIXEL-1:0] shift_q, shift_d;
    logic [BC_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [PC_W-1:0]           pix_cnt_q, pix_cnt_d;
    logic                      overflow_q, overflow_d;
    logic                      wr_en_q, wr_en_d;
    logic [ADDR_BITS-1:0]      wr_addr_q, wr_addr_d;
    logic [BITS_PER_PIXEL-1:0] wr_data_q, wr_data_d;
    logic                      wr_buffer_q, wr_buffer_d;
    logic                      frame_done_q, frame_done_d;
    logic                      frame_error_q, frame_error_d;
    logic                      miso_q, miso_d;

    logic sclk_rise;
    logic ss_fall;
    logic ss_high;

    always_comb begin
        sclk_sync_d   = {sclk_sync_q[1:0], spi_clk};
        mosi_sync_d   = {mosi_sync_q[0], spi_mosi};
        ss_sync_d     = {ss_sync_q[1:0], spi_ss};
        sclk_rise     = sclk_sync_q[1] & ~sclk_sync_q[2];
        ss_fall       = ~ss_sync_q[1] & ss_sync_q[2];
        ss_high       = ss_sync_q[1];

        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        pix_cnt_d     = pix_cnt_q;
        overflow_d    = overflow_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        wr_buffer_d   = wr_buffer_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        miso_d        = miso_q;

        case (state_q)
            IDLE: begin
                if (ss_fall) begin
                    state_d    = RECEIVE;
                    shift_d    = '0;
                    bit_cnt_d  = '0;
                    pix_cnt_d  = '0;
                    overflow_d = 1'b0;
                end
            end
            RECEIVE: begin
                // ss is checked as a level so a deassert seen during COMMIT is handled here next cycle
                if (ss_high) begin
                    state_d = IDLE;
                    if (pix_cnt_q == PIX_FULL && bit_cnt_q == '0 && !overflow_q) begin
                        wr_buffer_d  = ~wr_buffer_q;
                        frame_done_d = 1'b1;
                        miso_d       = 1'b1;
                    end else if (!(pix_cnt_q == '0 && bit_cnt_q == '0)) begin
                        frame_error_d = 1'b1;
                        miso_d        = 1'b0;
                    end
                end else if (sclk_rise) begin
                    shift_d = BITS_PER_PIXEL'({shift_q, mosi_sync_q[1]});
                    if (bit_cnt_q == BIT_LAST) begin
                        bit_cnt_d = '0;
                        if (pix_cnt_q < PIX_FULL) begin
                            state_d = COMMIT;
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BC_W'(1);
                    end
                end
            end
            COMMIT: begin
                wr_en_d   = 1'b1;
                wr_addr_d = pix_cnt_q[ADDR_BITS-1:0];
                wr_data_d = shift_q;
                pix_cnt_d = pix_cnt_q + PC_W'(1);
                state_d   = RECEIVE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Sync chains reset to the bus idle levels (ss high, sclk low) so reset itself creates no edges.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            sclk_sync_q   <= '0;
            mosi_sync_q   <= '0;
            ss_sync_q     <= '1;
            shift_q       <= '0;
            bit_cnt_q     <= '0;
            pix_cnt_q     <= '0;
            overflow_q    <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            wr_buffer_q   <= 1'b1;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            miso_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sclk_sync_q   <= sclk_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            ss_sync_q     <= ss_sync_d;
            shift_q       <= shift_d;
            bit_cnt_q     <= bit_cnt_d;
            pix_cnt_q     <= pix_cnt_d;
            overflow_q    <= overflow_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            wr_buffer_q   <= wr_buffer_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
            miso_q        <= miso_d;
        end
    end

    assign wr_if.wr_en          = wr_en_q;
    assign wr_if.wr_addr        = wr_addr_q;
    assign wr_if.wr_data        = wr_data_q;
    assign wr_if.wr_buffer      = wr_buffer_q;
    assign wr_if.display_buffer = ~wr_buffer_q;
    assign wr_if.frame_done     = frame_done_q;
    assign wr_if.frame_error    = frame_error_q;
    assign spi_miso             = miso_q;

endmodule
